fault_collect_cam: RTL and testbench
====================================

Name: fault_collect_cam

Overview:
- Upstream stage of the spare allocation analyzer in the BIRA path.
- Accepts fault (row, col) addresses from BIST one at a time.
- Classifies each fault as pivot (new row and new column) or non-pivot (shares a row or column with a stored pivot), and fills the pivot CAM and non-pivot CAM images the analyzer consumes.
- Tracks must-repair lines and flags unrepairable dies early.

Parameters:
- PCAM, 8, pivot CAM entries; equals SPARE_R + SPARE_C.
- NPCAM, 30, non-pivot CAM entries.
- SPARE_R, 4, spare rows available.
- SPARE_C, 4, spare columns available.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- fault_valid  in  1  BIST fault address valid
- fault_ready  out  1  block can accept a fault this cycle
- fault_row  in  10  faulty row address
- fault_col  in  10  faulty column address
- bist_done  in  1  BIST finished, no more faults
- pivot_fault_addr  out  PCAM x 26  pivot CAM image: [25] valid, [24:15] row, [14:5] col, [4] row must-repair, [3] col must-repair, [2:0] zero
- nonpivot_fault_addr  out  NPCAM x 17  non-pivot image: [16] valid, [15:13] pivot index, [12] dir (0 = shares pivot row, [9:0] holds col; 1 = shares pivot col, [9:0] holds row), [11:10] zero, [9:0] address
- pcam_cnt  out  4  valid pivot entries
- npcam_cnt  out  5  valid non-pivot entries
- collect_done  out  1  collection finished, CAM images stable
- unrepairable  out  1  die cannot be repaired

Behaviour:
- Reset (rst_n low at a clk edge) clears all outputs to 0 and all CAM entries, counters and must flags; state goes to COLLECT. Reset applied mid-operation discards any in-flight fault.
- State COLLECT: fault_ready = 1. A fault is accepted when fault_valid && fault_ready at an edge; it is captured into a stage register and the state moves to UPDATE.
- State UPDATE (one cycle): fault_ready = 0. Compare the captured fault against all valid pivots in parallel, then write the result at the end of the cycle and return to COLLECT. Throughput is one fault per 2 cycles. The CAM image updates on the edge that ends UPDATE.
- Classification, in priority order:
  - Exact row and col match with a pivot, or match with a non-pivot entry: drop the fault; no counter change.
  - Row match with one or more pivots: non-pivot, dir = 0, pointer = lowest matching index, address = col.
  - Otherwise, col match: non-pivot, dir = 1, pointer = lowest matching index, address = row.
  - Otherwise: new pivot at index pcam_cnt.
- Per-pivot 3-bit saturating counters:
  - row_cnt starts at 1 when the pivot is written and increments on each dir = 0 attach.
  - col_cnt starts at 1 and increments on each dir = 1 attach.
  - row_cnt > SPARE_C sets bit [4]; col_cnt > SPARE_R sets bit [3]. Both flags are sticky.
- Overflow: a new pivot with pcam_cnt == PCAM, or a new non-pivot with npcam_cnt == NPCAM, sets unrepairable, goes to DONE, and leaves the CAMs unchanged.
- bist_done:
  - Sampled high in COLLECT (with no fault accepted in the same cycle): go to DONE.
  - Sampled high in UPDATE: finish the update, then go to DONE.
  - If fault_valid and bist_done are both high in COLLECT, accept the fault and finish its update before DONE.
- State DONE: collect_done = 1, fault_ready = 0, all outputs held until reset.
- unrepairable is sticky until reset.

Optional Feature:
- Macro: FAULT_COLLECT_EARLY_TERM_EN.
- Defined:
  - A count of pivots with the row must flag greater than SPARE_R sets unrepairable and goes to DONE on the next cycle.
  - A count of pivots with the col must flag greater than SPARE_C does the same.
- Undefined: must flags are reported only; unrepairable is raised solely by CAM overflow.

Test Plan:
- Reset, then faults (5,7), (9,3): both become pivots at indices 0 and 1, pcam_cnt = 2, fault_ready low exactly one cycle after each accept.
- Pivot (5,7), then (5,20), then (40,7): NP0 = {1,0,0,...,20}, NP1 = {1,0,1,...,40}, npcam_cnt = 2; a repeated (5,20) is dropped.
- 5 faults in row 5 with distinct columns (SPARE_C = 4): pivot 0 bit [4] = 1 after the 5th fault is written; bit [3] = 0.
- 9 faults with distinct rows and distinct columns: the 9th sets unrepairable = 1 and collect_done = 1; pcam_cnt stays 8.
- bist_done and fault_valid high together in COLLECT: fault is stored, collect_done = 1 two cycles later. Asserting rst_n = 0 while in UPDATE clears all outputs on the next edge.
- With FAULT_COLLECT_EARLY_TERM_EN defined: 5 pivots each with row-must set (SPARE_R = 4) raise unrepairable. Without the macro, only the flags are set.

Source files
------------

// File: rtl/fault_collect_cam_if.sv
// Fault handshake between the BIST engine and the fault collection CAM.
// The master side (BIST) presents fault addresses and the end-of-test flag;
// the slave side (collector) returns fault_ready.
interface fault_collect_cam_if;
  logic       fault_valid;
  logic       fault_ready;
  logic [9:0] fault_row;
  logic [9:0] fault_col;
  logic       bist_done;

  modport master (
    output fault_valid,
    output fault_row,
    output fault_col,
    output bist_done,
    input  fault_ready
  );

  modport slave (
    input  fault_valid,
    input  fault_row,
    input  fault_col,
    input  bist_done,
    output fault_ready
  );
endinterface

// File: rtl/fault_collect_cam.sv
// fault_collect_cam: front end of the BIRA spare allocation analyzer.
// Collects BIST fault addresses one at a time, sorts them into pivot and
// non-pivot CAM images, tracks per-pivot must-repair flags and flags a die
// as unrepairable when either CAM overflows.
// Optional build macro FAULT_COLLECT_EARLY_TERM_EN: when defined, too many
// row-must or col-must pivots also declare the die unrepairable and stop
// collection one cycle later.
module fault_collect_cam #(
  parameter int PCAM    = 8,
  parameter int NPCAM   = 30,
  parameter int SPARE_R = 4,
  parameter int SPARE_C = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fault_collect_cam_if.slave      fault_if,
  output logic [PCAM-1:0][25:0]   pivot_fault_addr,
  output logic [NPCAM-1:0][16:0]  nonpivot_fault_addr,
  output logic [3:0]              pcam_cnt,
  output logic [4:0]              npcam_cnt,
  output logic                    collect_done,
  output logic                    unrepairable
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    UPDATE  = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [3:0] PCAM_FULL  = 4'(PCAM);
  localparam logic [4:0] NPCAM_FULL = 5'(NPCAM);
  localparam logic [2:0] ROW_LIMIT  = 3'(SPARE_C);
  localparam logic [2:0] COL_LIMIT  = 3'(SPARE_R);

  state_t state_q, state_d;

  // Stage register holding the fault under classification
  logic [9:0] stage_row_q, stage_row_d;
  logic [9:0] stage_col_q, stage_col_d;
  logic       done_pend_q, done_pend_d;

  // Pivot CAM storage
  logic [PCAM-1:0]        pv_valid_q, pv_valid_d;
  logic [PCAM-1:0][9:0]   pv_row_q, pv_row_d;
  logic [PCAM-1:0][9:0]   pv_col_q, pv_col_d;
  logic [PCAM-1:0][2:0]   pv_rcnt_q, pv_rcnt_d;
  logic [PCAM-1:0][2:0]   pv_ccnt_q, pv_ccnt_d;
  logic [PCAM-1:0]        pv_rmust_q, pv_rmust_d;
  logic [PCAM-1:0]        pv_cmust_q, pv_cmust_d;

  // Non-pivot CAM storage
  logic [NPCAM-1:0]       np_valid_q, np_valid_d;
  logic [NPCAM-1:0][2:0]  np_idx_q, np_idx_d;
  logic [NPCAM-1:0]       np_dir_q, np_dir_d;
  logic [NPCAM-1:0][9:0]  np_addr_q, np_addr_d;

  logic [3:0] pcam_cnt_q, pcam_cnt_d;
  logic [4:0] npcam_cnt_q, npcam_cnt_d;
  logic       unrep_q, unrep_d;

  // Match results for the staged fault
  logic       exact_hit;
  logic       row_hit;
  logic       col_hit;
  logic [2:0] row_idx;
  logic [2:0] col_idx;
  logic [2:0] rcnt_next;
  logic [2:0] ccnt_next;
  logic       early_stop;
  logic       overflow;

`ifdef FAULT_COLLECT_EARLY_TERM_EN
  logic [3:0] rmust_cnt;
  logic [3:0] cmust_cnt;

  // Count must-repair pivots; more than the spare budget means no repair fits
  always_comb begin
    rmust_cnt = '0;
    cmust_cnt = '0;
    for (int i = 0; i < PCAM; i++) begin
      rmust_cnt = rmust_cnt + {3'b000, pv_rmust_q[i]};
      cmust_cnt = cmust_cnt + {3'b000, pv_cmust_q[i]};
    end
    early_stop = (rmust_cnt > 4'(SPARE_R)) || (cmust_cnt > 4'(SPARE_C));
  end
`else
  assign early_stop = 1'b0;
`endif

  // Compare the staged fault against every valid pivot and non-pivot entry;
  // scanning pivots downward leaves the lowest matching index selected
  always_comb begin
    exact_hit = 1'b0;
    row_hit   = 1'b0;
    col_hit   = 1'b0;
    row_idx   = '0;
    col_idx   = '0;
    for (int i = PCAM - 1; i >= 0; i--) begin
      if (pv_valid_q[i]) begin
        if (pv_row_q[i] == stage_row_q) begin
          row_hit = 1'b1;
          row_idx = 3'(i);
        end
        if (pv_col_q[i] == stage_col_q) begin
          col_hit = 1'b1;
          col_idx = 3'(i);
        end
        if (pv_row_q[i] == stage_row_q && pv_col_q[i] == stage_col_q) begin
          exact_hit = 1'b1;
        end
      end
    end
    for (int j = 0; j < NPCAM; j++) begin
      if (np_valid_q[j]) begin
        if (!np_dir_q[j]) begin
          if (pv_row_q[np_idx_q[j]] == stage_row_q && np_addr_q[j] == stage_col_q) begin
            exact_hit = 1'b1;
          end
        end else begin
          if (np_addr_q[j] == stage_row_q && pv_col_q[np_idx_q[j]] == stage_col_q) begin
            exact_hit = 1'b1;
          end
        end
      end
    end
  end

  // Saturating increments of the attach counters of the selected pivots
  always_comb begin
    rcnt_next = pv_rcnt_q[row_idx];
    ccnt_next = pv_ccnt_q[col_idx];
    if (pv_rcnt_q[row_idx] != 3'd7) rcnt_next = pv_rcnt_q[row_idx] + 3'd1;
    if (pv_ccnt_q[col_idx] != 3'd7) ccnt_next = pv_ccnt_q[col_idx] + 3'd1;
  end

  // Control FSM plus CAM write path: accept in COLLECT, classify and write in UPDATE
  always_comb begin
    state_d     = state_q;
    stage_row_d = stage_row_q;
    stage_col_d = stage_col_q;
    done_pend_d = done_pend_q;
    pv_valid_d  = pv_valid_q;
    pv_row_d    = pv_row_q;
    pv_col_d    = pv_col_q;
    pv_rcnt_d   = pv_rcnt_q;
    pv_ccnt_d   = pv_ccnt_q;
    pv_rmust_d  = pv_rmust_q;
    pv_cmust_d  = pv_cmust_q;
    np_valid_d  = np_valid_q;
    np_idx_d    = np_idx_q;
    np_dir_d    = np_dir_q;
    np_addr_d   = np_addr_q;
    pcam_cnt_d  = pcam_cnt_q;
    npcam_cnt_d = npcam_cnt_q;
    unrep_d     = unrep_q;
    overflow    = 1'b0;

    case (state_q)
      COLLECT: begin
        if (early_stop) begin
          unrep_d = 1'b1;
          state_d = DONE;
        end else if (fault_if.fault_valid) begin
          stage_row_d = fault_if.fault_row;
          stage_col_d = fault_if.fault_col;
          done_pend_d = fault_if.bist_done;
          state_d     = UPDATE;
        end else if (fault_if.bist_done) begin
          state_d = DONE;
        end
      end

      UPDATE: begin
        if (exact_hit) begin
          // Duplicate fault: already represented in a CAM
        end else if (row_hit || col_hit) begin
          if (npcam_cnt_q == NPCAM_FULL) begin
            overflow = 1'b1;
          end else begin
            for (int j = 0; j < NPCAM; j++) begin
              if (5'(j) == npcam_cnt_q) begin
                np_valid_d[j] = 1'b1;
                np_idx_d[j]   = row_hit ? row_idx : col_idx;
                np_dir_d[j]   = !row_hit;
                np_addr_d[j]  = row_hit ? stage_col_q : stage_row_q;
              end
            end
            npcam_cnt_d = npcam_cnt_q + 5'd1;
            if (row_hit) begin
              pv_rcnt_d[row_idx] = rcnt_next;
              if (rcnt_next > ROW_LIMIT) pv_rmust_d[row_idx] = 1'b1;
            end else begin
              pv_ccnt_d[col_idx] = ccnt_next;
              if (ccnt_next > COL_LIMIT) pv_cmust_d[col_idx] = 1'b1;
            end
          end
        end else begin
          if (pcam_cnt_q == PCAM_FULL) begin
            overflow = 1'b1;
          end else begin
            for (int i = 0; i < PCAM; i++) begin
              if (4'(i) == pcam_cnt_q) begin
                pv_valid_d[i] = 1'b1;
                pv_row_d[i]   = stage_row_q;
                pv_col_d[i]   = stage_col_q;
                pv_rcnt_d[i]  = 3'd1;
                pv_ccnt_d[i]  = 3'd1;
                pv_rmust_d[i] = 1'b0;
                pv_cmust_d[i] = 1'b0;
              end
            end
            pcam_cnt_d = pcam_cnt_q + 4'd1;
          end
        end
        if (overflow) unrep_d = 1'b1;
        if (overflow || done_pend_q || fault_if.bist_done) begin
          state_d = DONE;
        end else begin
          state_d = COLLECT;
        end
      end

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State and CAM registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      stage_row_q <= '0;
      stage_col_q <= '0;
      done_pend_q <= 1'b0;
      pv_valid_q  <= '0;
      pv_row_q    <= '0;
      pv_col_q    <= '0;
      pv_rcnt_q   <= '0;
      pv_ccnt_q   <= '0;
      pv_rmust_q  <= '0;
      pv_cmust_q  <= '0;
      np_valid_q  <= '0;
      np_idx_q    <= '0;
      np_dir_q    <= '0;
      np_addr_q   <= '0;
      pcam_cnt_q  <= '0;
      npcam_cnt_q <= '0;
      unrep_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_row_q <= stage_row_d;
      stage_col_q <= stage_col_d;
      done_pend_q <= done_pend_d;
      pv_valid_q  <= pv_valid_d;
      pv_row_q    <= pv_row_d;
      pv_col_q    <= pv_col_d;
      pv_rcnt_q   <= pv_rcnt_d;
      pv_ccnt_q   <= pv_ccnt_d;
      pv_rmust_q  <= pv_rmust_d;
      pv_cmust_q  <= pv_cmust_d;
      np_valid_q  <= np_valid_d;
      np_idx_q    <= np_idx_d;
      np_dir_q    <= np_dir_d;
      np_addr_q   <= np_addr_d;
      pcam_cnt_q  <= pcam_cnt_d;
      npcam_cnt_q <= npcam_cnt_d;
      unrep_q     <= unrep_d;
    end
  end

  // Pack the stored entries into the CAM images the analyzer reads
  always_comb begin
    pivot_fault_addr    = '0;
    nonpivot_fault_addr = '0;
    for (int i = 0; i < PCAM; i++) begin
      pivot_fault_addr[i] = {pv_valid_q[i], pv_row_q[i], pv_col_q[i],
                             pv_rmust_q[i], pv_cmust_q[i], 3'b000};
    end
    for (int j = 0; j < NPCAM; j++) begin
      nonpivot_fault_addr[j] = {np_valid_q[j], np_idx_q[j], np_dir_q[j],
                                2'b00, np_addr_q[j]};
    end
  end

  assign fault_if.fault_ready = (state_q == COLLECT) && !early_stop;
  assign pcam_cnt             = pcam_cnt_q;
  assign npcam_cnt            = npcam_cnt_q;
  assign collect_done         = (state_q == DONE);
  assign unrepairable         = unrep_q;

endmodule

// File: tb/tb_fault_collect_cam.sv
// Directed testbench for fault_collect_cam: pivot/non-pivot sorting,
// must-repair flags, CAM overflow, bist_done handling and reset.
module tb_fault_collect_cam;

  logic clk;
  logic rst_n;
  logic [7:0][25:0]  pfa;
  logic [29:0][16:0] npa;
  logic [3:0] pcam_cnt;
  logic [4:0] npcam_cnt;
  logic       collect_done;
  logic       unrepairable;

  int   vectors;
  int   errors;
  logic rdy_in_update;
  logic rdy_after;

  fault_collect_cam_if fif ();

  fault_collect_cam dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fault_if            (fif),
    .pivot_fault_addr    (pfa),
    .nonpivot_fault_addr (npa),
    .pcam_cnt            (pcam_cnt),
    .npcam_cnt           (npcam_cnt),
    .collect_done        (collect_done),
    .unrepairable        (unrepairable)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n           = 1'b0;
    fif.fault_valid = 1'b0;
    fif.bist_done   = 1'b0;
    fif.fault_row   = '0;
    fif.fault_col   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Offer one fault, wait through the accept edge and the update edge
  task automatic send_fault(input logic [9:0] r, input logic [9:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (!fif.fault_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!fif.fault_ready) begin
      errors++;
      $display("[TB] FAIL send_timeout fault (%0d,%0d) ready stayed low", r, c);
    end else begin
      fif.fault_valid = 1'b1;
      fif.fault_row   = r;
      fif.fault_col   = c;
      @(posedge clk);
      #1 fif.fault_valid = 1'b0;
      rdy_in_update = fif.fault_ready;
      @(posedge clk);
      #1 rdy_after = fif.fault_ready;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (pcam_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_pcam_cnt got %0d exp 0", pcam_cnt); end
    vectors++; if (npcam_cnt !== 5'd0) begin errors++; $display("[TB] FAIL reset_npcam_cnt got %0d exp 0", npcam_cnt); end
    vectors++; if (collect_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b exp 0", collect_done); end
    vectors++; if (unrepairable !== 1'b0) begin errors++; $display("[TB] FAIL reset_unrep got %b exp 0", unrepairable); end
    vectors++; if (pfa !== '0) begin errors++; $display("[TB] FAIL reset_pivot_image got %h exp 0", pfa); end
    vectors++; if (npa !== '0) begin errors++; $display("[TB] FAIL reset_np_image got %h exp 0", npa); end
    vectors++; if (fif.fault_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b exp 1", fif.fault_ready); end
  endtask

  task automatic test_pivots();
    logic [25:0] ep;
    logic [16:0] en;
    do_reset();
    send_fault(10'd5, 10'd7);
    vectors++; if (rdy_in_update !== 1'b0) begin errors++; $display("[TB] FAIL ready_in_update got %b exp 0", rdy_in_update); end
    vectors++; if (rdy_after !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_update got %b exp 1", rdy_after); end
    send_fault(10'd9, 10'd3);
    vectors++; if (rdy_in_update !== 1'b0) begin errors++; $display("[TB] FAIL ready_in_update2 got %b exp 0", rdy_in_update); end
    vectors++; if (pcam_cnt !== 4'd2) begin errors++; $display("[TB] FAIL pivots_pcam_cnt got %0d exp 2", pcam_cnt); end
    ep = {1'b1, 10'd5, 10'd7, 1'b0, 1'b0, 3'b000};
    vectors++; if (pfa[0] !== ep) begin errors++; $display("[TB] FAIL pivot0 got %h exp %h", pfa[0], ep); end
    ep = {1'b1, 10'd9, 10'd3, 1'b0, 1'b0, 3'b000};
    vectors++; if (pfa[1] !== ep) begin errors++; $display("[TB] FAIL pivot1 got %h exp %h", pfa[1], ep); end
    // (9,7) shares row with pivot 1 and col with pivot 0: row wins
    send_fault(10'd9, 10'd7);
    en = {1'b1, 3'd1, 1'b0, 2'b00, 10'd7};
    vectors++; if (npa[0] !== en) begin errors++; $display("[TB] FAIL row_priority got %h exp %h", npa[0], en); end
    vectors++; if (pcam_cnt !== 4'd2) begin errors++; $display("[TB] FAIL row_priority_pcam got %0d exp 2", pcam_cnt); end
  endtask

  task automatic test_nonpivot();
    logic [16:0] en;
    do_reset();
    send_fault(10'd5, 10'd7);
    send_fault(10'd5, 10'd20);
    send_fault(10'd40, 10'd7);
    en = {1'b1, 3'd0, 1'b0, 2'b00, 10'd20};
    vectors++; if (npa[0] !== en) begin errors++; $display("[TB] FAIL np0 got %h exp %h", npa[0], en); end
    en = {1'b1, 3'd0, 1'b1, 2'b00, 10'd40};
    vectors++; if (npa[1] !== en) begin errors++; $display("[TB] FAIL np1 got %h exp %h", npa[1], en); end
    vectors++; if (npcam_cnt !== 5'd2) begin errors++; $display("[TB] FAIL np_cnt got %0d exp 2", npcam_cnt); end
    send_fault(10'd5, 10'd20);
    send_fault(10'd40, 10'd7);
    send_fault(10'd5, 10'd7);
    vectors++; if (npcam_cnt !== 5'd2) begin errors++; $display("[TB] FAIL dup_np_cnt got %0d exp 2", npcam_cnt); end
    vectors++; if (pcam_cnt !== 4'd1) begin errors++; $display("[TB] FAIL dup_pcam_cnt got %0d exp 1", pcam_cnt); end
    vectors++; if (npa[2] !== 17'd0) begin errors++; $display("[TB] FAIL dup_np2 got %h exp 0", npa[2]); end
  endtask

  task automatic test_row_must();
    do_reset();
    for (int j = 1; j <= 4; j++) send_fault(10'd5, 10'(j));
    vectors++; if (pfa[0][4] !== 1'b0) begin errors++; $display("[TB] FAIL row_must_early got %b exp 0", pfa[0][4]); end
    send_fault(10'd5, 10'd5);
    vectors++; if (pfa[0][4] !== 1'b1) begin errors++; $display("[TB] FAIL row_must got %b exp 1", pfa[0][4]); end
    vectors++; if (pfa[0][3] !== 1'b0) begin errors++; $display("[TB] FAIL col_must got %b exp 0", pfa[0][3]); end
    vectors++; if (npcam_cnt !== 5'd4) begin errors++; $display("[TB] FAIL row_must_np_cnt got %0d exp 4", npcam_cnt); end
    // Five faults in col 50 under a new pivot: col-must on pivot 1
    for (int j = 0; j < 5; j++) send_fault(10'(100 + j), 10'd50);
    vectors++; if (pfa[1][3] !== 1'b1) begin errors++; $display("[TB] FAIL col_must1 got %b exp 1", pfa[1][3]); end
    vectors++; if (pfa[1][4] !== 1'b0) begin errors++; $display("[TB] FAIL row_must1 got %b exp 0", pfa[1][4]); end
  endtask

  task automatic test_overflow();
    logic [25:0] ep;
    do_reset();
    for (int i = 0; i < 8; i++) send_fault(10'(10 + i), 10'(100 + i));
    vectors++; if (pcam_cnt !== 4'd8) begin errors++; $display("[TB] FAIL full_pcam got %0d exp 8", pcam_cnt); end
    vectors++; if (unrepairable !== 1'b0) begin errors++; $display("[TB] FAIL full_unrep got %b exp 0", unrepairable); end
    send_fault(10'd18, 10'd108);
    vectors++; if (unrepairable !== 1'b1) begin errors++; $display("[TB] FAIL ovf_unrep got %b exp 1", unrepairable); end
    vectors++; if (collect_done !== 1'b1) begin errors++; $display("[TB] FAIL ovf_done got %b exp 1", collect_done); end
    vectors++; if (pcam_cnt !== 4'd8) begin errors++; $display("[TB] FAIL ovf_pcam got %0d exp 8", pcam_cnt); end
    ep = {1'b1, 10'd17, 10'd107, 1'b0, 1'b0, 3'b000};
    vectors++; if (pfa[7] !== ep) begin errors++; $display("[TB] FAIL ovf_pivot7 got %h exp %h", pfa[7], ep); end
    vectors++; if (rdy_after !== 1'b0) begin errors++; $display("[TB] FAIL ovf_ready got %b exp 0", rdy_after); end
    // Non-pivot CAM overflow
    do_reset();
    send_fault(10'd1, 10'd0);
    for (int j = 1; j <= 30; j++) send_fault(10'd1, 10'(j));
    vectors++; if (npcam_cnt !== 5'd30) begin errors++; $display("[TB] FAIL np_full got %0d exp 30", npcam_cnt); end
    vectors++; if (unrepairable !== 1'b0) begin errors++; $display("[TB] FAIL np_full_unrep got %b exp 0", unrepairable); end
    send_fault(10'd1, 10'd31);
    vectors++; if (unrepairable !== 1'b1) begin errors++; $display("[TB] FAIL np_ovf_unrep got %b exp 1", unrepairable); end
    vectors++; if (collect_done !== 1'b1) begin errors++; $display("[TB] FAIL np_ovf_done got %b exp 1", collect_done); end
    vectors++; if (npcam_cnt !== 5'd30) begin errors++; $display("[TB] FAIL np_ovf_cnt got %0d exp 30", npcam_cnt); end
  endtask

  task automatic test_bist_done();
    do_reset();
    @(negedge clk);
    fif.fault_valid = 1'b1;
    fif.fault_row   = 10'd7;
    fif.fault_col   = 10'd7;
    fif.bist_done   = 1'b1;
    @(posedge clk);
    #1 fif.fault_valid = 1'b0;
    fif.bist_done = 1'b0;
    vectors++; if (collect_done !== 1'b0) begin errors++; $display("[TB] FAIL done_early got %b exp 0", collect_done); end
    @(posedge clk);
    #1;
    vectors++; if (collect_done !== 1'b1) begin errors++; $display("[TB] FAIL done_after_fault got %b exp 1", collect_done); end
    vectors++; if (pcam_cnt !== 4'd1) begin errors++; $display("[TB] FAIL done_fault_stored got %0d exp 1", pcam_cnt); end
    // Further faults are ignored in DONE
    @(negedge clk);
    fif.fault_valid = 1'b1;
    fif.fault_row   = 10'd3;
    fif.fault_col   = 10'd4;
    repeat (3) @(posedge clk);
    #1 fif.fault_valid = 1'b0;
    vectors++; if (pcam_cnt !== 4'd1) begin errors++; $display("[TB] FAIL done_hold got %0d exp 1", pcam_cnt); end
    vectors++; if (fif.fault_ready !== 1'b0) begin errors++; $display("[TB] FAIL done_ready got %b exp 0", fif.fault_ready); end
    // bist_done alone in COLLECT
    do_reset();
    @(negedge clk);
    fif.bist_done = 1'b1;
    @(posedge clk);
    #1 fif.bist_done = 1'b0;
    vectors++; if (collect_done !== 1'b1) begin errors++; $display("[TB] FAIL bist_only_done got %b exp 1", collect_done); end
    vectors++; if (pcam_cnt !== 4'd0) begin errors++; $display("[TB] FAIL bist_only_pcam got %0d exp 0", pcam_cnt); end
  endtask

  task automatic test_reset_in_update();
    do_reset();
    send_fault(10'd2, 10'd2);
    @(negedge clk);
    fif.fault_valid = 1'b1;
    fif.fault_row   = 10'd3;
    fif.fault_col   = 10'd4;
    @(posedge clk);
    #1 fif.fault_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    vectors++; if (pcam_cnt !== 4'd0) begin errors++; $display("[TB] FAIL rst_upd_pcam got %0d exp 0", pcam_cnt); end
    vectors++; if (pfa !== '0) begin errors++; $display("[TB] FAIL rst_upd_image got %h exp 0", pfa); end
    vectors++; if (collect_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_upd_done got %b exp 0", collect_done); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (pcam_cnt !== 4'd0) begin errors++; $display("[TB] FAIL rst_upd_discard got %0d exp 0", pcam_cnt); end
  endtask

  task automatic test_early_term();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 5; j++) send_fault(10'(10 * (k + 1)), 10'(100 + 10 * k + j));
    end
    @(posedge clk);
    #1;
    vectors++; if (pfa[0][4] !== 1'b1) begin errors++; $display("[TB] FAIL et_flag0 got %b exp 1", pfa[0][4]); end
    vectors++; if (pfa[4][4] !== 1'b1) begin errors++; $display("[TB] FAIL et_flag4 got %b exp 1", pfa[4][4]); end
    vectors++; if (npcam_cnt !== 5'd20) begin errors++; $display("[TB] FAIL et_np_cnt got %0d exp 20", npcam_cnt); end
`ifdef FAULT_COLLECT_EARLY_TERM_EN
    vectors++; if (unrepairable !== 1'b1) begin errors++; $display("[TB] FAIL et_unrep got %b exp 1", unrepairable); end
    vectors++; if (collect_done !== 1'b1) begin errors++; $display("[TB] FAIL et_done got %b exp 1", collect_done); end
`else
    vectors++; if (unrepairable !== 1'b0) begin errors++; $display("[TB] FAIL et_unrep got %b exp 0", unrepairable); end
    vectors++; if (collect_done !== 1'b0) begin errors++; $display("[TB] FAIL et_done got %b exp 0", collect_done); end
`endif
  endtask

  // Run all scenarios in order, then report
  initial begin
    vectors       = 0;
    errors        = 0;
    rdy_in_update = 1'b0;
    rdy_after     = 1'b0;
    test_reset();
    test_pivots();
    test_nonpivot();
    test_row_must();
    test_overflow();
    test_bist_done();
    test_reset_in_update();
    test_early_term();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
